// File: rtl/gate_response_checker.sv
// Response monitor for a 3-input gate: judges each (A,B,C,Q) sample against TRUTH_TABLE.
// Define CHECKER_STOP_ON_FAIL_EN to end checking at the first mismatch.
module gate_response_checker #(
   parameter logic [7:0] TRUTH_TABLE = 8'hEA,
   parameter int         CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             Q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] sample_count,
   output logic [7:0]       coverage,
   output logic [2:0]       first_fail_idx
);

   typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

   state_t           state, next_state;
   logic [2:0]       idx;
   logic             expected;
   logic             mismatch;
   logic [7:0]       cov_with_idx;
   logic [7:0]       coverage_next;
   logic [CNT_W-1:0] err_next;
   logic [CNT_W-1:0] sample_next;
   logic [2:0]       ffi_next;
   logic             fail_next;
   logic             pass_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_pulse     <= 1'b0;
         err_count      <= '0;
         sample_count   <= '0;
         coverage       <= '0;
         first_fail_idx <= '0;
      end else begin
         state          <= next_state;
         busy           <= (next_state == CHECK);
         done           <= (next_state == DONE);
         pass           <= pass_next;
         fail_pulse     <= fail_next;
         err_count      <= err_next;
         sample_count   <= sample_next;
         coverage       <= coverage_next;
         first_fail_idx <= ffi_next;
      end
   end

   // start wins over in_valid in every state, so a sample arriving with start is dropped
   always_comb begin
      idx           = {A, B, C};
      expected      = TRUTH_TABLE[idx];
      mismatch      = (Q != expected);
      cov_with_idx  = coverage | (8'b1 << idx);
      next_state    = state;
      coverage_next = coverage;
      err_next      = err_count;
      sample_next   = sample_count;
      ffi_next      = first_fail_idx;
      fail_next     = 1'b0;

      if (start) begin
         next_state    = CHECK;
         coverage_next = '0;
         err_next      = '0;
         sample_next   = '0;
         ffi_next      = '0;
      end else begin
         case (state)
            IDLE: next_state = IDLE;
            CHECK: begin
               if (in_valid) begin
                  coverage_next = cov_with_idx;
                  if (!(&sample_count))
                     sample_next = sample_count + 1'b1;
                  if (mismatch) begin
                     fail_next = 1'b1;
                     if (!(&err_count))
                        err_next = err_count + 1'b1;
                     if (err_count == '0)
                        ffi_next = idx;
                  end
                  if (cov_with_idx == 8'hFF)
                     next_state = DONE;
`ifdef CHECKER_STOP_ON_FAIL_EN
                  if (mismatch)
                     next_state = DONE;
`endif
               end
            end
            DONE: next_state = DONE;
            default: next_state = IDLE;
         endcase
      end

      pass_next = (next_state == DONE) && (err_next == '0);
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// Table-driven bench for gate_response_checker; a second instance (CNT_W=2,
// inverted table) exercises counter saturation.
module tb_gate_response_checker;

   logic       clk = 1'b0;
   logic       rst_n, start, in_valid, A, B, C, Q;
   logic       busy, done, pass, fail_pulse;
   logic [7:0] err_count, sample_count, coverage;
   logic [2:0] first_fail_idx;
   logic       s_busy, s_done, s_pass, s_fail_pulse;
   logic [1:0] s_err_count, s_sample_count;
   logic [7:0] s_coverage;
   logic [2:0] s_first_fail_idx;

   typedef struct {
      bit       rstn, st, v;
      bit [2:0] idx;
      bit       q;
      bit [7:0] cov, sc, ec;
      bit [2:0] ffi;
      bit       fp, busy, done, pass;
      bit       chk_sat;
      bit [1:0] sat_ec, sat_sc;
      bit       sat_fp;
   } vec_t;

   vec_t     vecs[$];
   vec_t     expq[$];
   int       tests, fails;
   bit [7:0] tt = 8'hEA;
   int       ord[7] = '{0, 1, 2, 3, 4, 5, 7};

   always #5 clk = ~clk;

   gate_response_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .Q(Q),
      .busy(busy), .done(done), .pass(pass), .fail_pulse(fail_pulse),
      .err_count(err_count), .sample_count(sample_count),
      .coverage(coverage), .first_fail_idx(first_fail_idx)
   );

   gate_response_checker #(.TRUTH_TABLE(8'h15), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .A(A), .B(B), .C(C), .Q(Q),
      .busy(s_busy), .done(s_done), .pass(s_pass), .fail_pulse(s_fail_pulse),
      .err_count(s_err_count), .sample_count(s_sample_count),
      .coverage(s_coverage), .first_fail_idx(s_first_fail_idx)
   );

   function automatic void add(input bit rstn, input bit st, input bit v,
                               input bit [2:0] idx, input bit q,
                               input bit [7:0] cov, input bit [7:0] sc,
                               input bit [7:0] ec, input bit [2:0] ffi,
                               input bit fp, input bit bsy,
                               input bit dn, input bit ps);
      vec_t t;
      t.rstn = rstn; t.st = st; t.v = v; t.idx = idx; t.q = q;
      t.cov = cov; t.sc = sc; t.ec = ec; t.ffi = ffi;
      t.fp = fp; t.busy = bsy; t.done = dn; t.pass = ps;
      t.chk_sat = 1'b0; t.sat_ec = 2'd0; t.sat_sc = 2'd0; t.sat_fp = 1'b0;
      vecs.push_back(t);
   endfunction

   function automatic void addSat(input bit [1:0] ec, input bit [1:0] sc, input bit fp);
      vec_t t;
      t = vecs.pop_back();
      t.chk_sat = 1'b1; t.sat_ec = ec; t.sat_sc = sc; t.sat_fp = fp;
      vecs.push_back(t);
   endfunction

   task automatic cmp(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL vec %0d %s: got %0h, want %0h", n, name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t t);
      @(negedge clk);
      rst_n    = t.rstn;
      start    = t.st;
      in_valid = t.v;
      {A, B, C} = t.idx;
      Q        = t.q;
      expq.push_back(t);
   endtask

   task automatic checkOutput(input int n);
      vec_t t;
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL vec %0d scoreboard: got empty queue, want entry", n);
         return;
      end
      t = expq.pop_front();
      cmp("coverage", n, coverage, t.cov);
      cmp("sample_count", n, sample_count, t.sc);
      cmp("err_count", n, err_count, t.ec);
      cmp("first_fail_idx", n, {5'd0, first_fail_idx}, {5'd0, t.ffi});
      cmp("fail_pulse", n, {7'd0, fail_pulse}, {7'd0, t.fp});
      cmp("busy", n, {7'd0, busy}, {7'd0, t.busy});
      cmp("done", n, {7'd0, done}, {7'd0, t.done});
      cmp("pass", n, {7'd0, pass}, {7'd0, t.pass});
      if (t.chk_sat) begin
         cmp("sat_err_count", n, {6'd0, s_err_count}, {6'd0, t.sat_ec});
         cmp("sat_sample_count", n, {6'd0, s_sample_count}, {6'd0, t.sat_sc});
         cmp("sat_fail_pulse", n, {7'd0, s_fail_pulse}, {7'd0, t.sat_fp});
      end
   endtask

   initial begin
      bit [7:0] c;
      int       k;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      A = 1'b0; B = 1'b0; C = 1'b0; Q = 1'b0;
      tests = 0; fails = 0;

      // reset, then in_valid while IDLE is ignored
      add(0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);
      add(0, 0, 1, 3'd5, 1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);
      add(1, 0, 1, 3'd6, 0, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);

      // all eight indices answered correctly
      add(1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++)
         add(1, 0, 1, 3'(i), tt[i], 8'((16'h1 << (i + 1)) - 1), 8'(i + 1), 0, 3'd0,
             0, (i != 7), (i == 7), (i == 7));
      add(1, 0, 1, 3'd0, 1, 8'hFF, 8, 0, 3'd0, 0, 0, 1, 1);

      // idx 6 answered wrongly first, then the rest correctly
      add(1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
`ifdef CHECKER_STOP_ON_FAIL_EN
      add(1, 0, 1, 3'd6, 0, 8'h40, 1, 1, 3'd6, 1, 0, 1, 0);
      add(1, 0, 1, 3'd0, 0, 8'h40, 1, 1, 3'd6, 0, 0, 1, 0);
      add(1, 0, 1, 3'd1, 1, 8'h40, 1, 1, 3'd6, 0, 0, 1, 0);
`else
      add(1, 0, 1, 3'd6, 0, 8'h40, 1, 1, 3'd6, 1, 1, 0, 0);
      c = 8'h40;
      for (int j = 0; j < 7; j++) begin
         k = ord[j];
         c = c | 8'(1 << k);
         add(1, 0, 1, 3'(k), tt[k], c, 8'(j + 2), 1, 3'd6, 0, (j != 6), (j == 6), 0);
      end

      // first_fail_idx keeps the first mismatch; fail_pulse tracks each one
      add(1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      add(1, 0, 1, 3'd2, 1, 8'h04, 1, 1, 3'd2, 1, 1, 0, 0);
      add(1, 0, 1, 3'd5, 0, 8'h24, 2, 2, 3'd2, 1, 1, 0, 0);
      add(1, 0, 1, 3'd5, 1, 8'h24, 3, 2, 3'd2, 0, 1, 0, 0);
      add(1, 0, 0, 3'd3, 0, 8'h24, 3, 2, 3'd2, 0, 1, 0, 0);
`endif

      // repeated idx 0 adds samples but no coverage
      add(1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++)
         add(1, 0, 1, 3'd0, 0, 8'h01, 8'(i + 1), 0, 3'd0, 0, 1, 0, 0);
      for (int i = 1; i < 8; i++)
         add(1, 0, 1, 3'(i), tt[i], 8'((16'h1 << (i + 1)) - 1), 8'(i + 5), 0, 3'd0,
             0, (i != 7), (i == 7), (i == 7));

      // reset mid-CHECK after four samples
      add(1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         add(1, 0, 1, 3'(i), tt[i], 8'((16'h1 << (i + 1)) - 1), 8'(i + 1), 0, 3'd0,
             0, 1, 0, 0);
      add(0, 0, 1, 3'd4, 0, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);
      add(1, 0, 1, 3'd2, 0, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);
      add(1, 0, 1, 3'd7, 0, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);

      // start together with in_valid in CHECK
      add(1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      add(1, 0, 1, 3'd0, 1, 8'h01, 1, 1, 3'd0, 1, 1, 0, 0);
      add(1, 1, 1, 3'd1, 1, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      add(1, 0, 0, 3'd1, 1, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);

      // start together with in_valid in DONE
      for (int i = 0; i < 8; i++)
         add(1, 0, 1, 3'(i), tt[i], 8'((16'h1 << (i + 1)) - 1), 8'(i + 1), 0, 3'd0,
             0, (i != 7), (i == 7), (i == 7));
      add(1, 1, 1, 3'd5, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      add(1, 0, 0, 3'd5, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);

      // saturation on the narrow instance, whose table is inverted
      add(1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 0);
      addSat(2'd0, 2'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         add(1, 0, 1, 3'(i), tt[i], 8'((16'h1 << (i + 1)) - 1), 8'(i + 1), 0, 3'd0,
             0, 1, 0, 0);
`ifdef CHECKER_STOP_ON_FAIL_EN
         addSat(2'd1, 2'd1, (i == 0));
`else
         addSat(2'((i + 1 > 3) ? 3 : i + 1), 2'((i + 1 > 3) ? 3 : i + 1), 1'b1);
`endif
      end

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Self-checking response monitor for a 3-input combinational gate under test.
- Consumes (A,B,C,Q) samples from a stimulus source or DUT harness and compares each Q against a parameterised golden truth table.
- Tracks input-combination coverage and mismatch counts, and reports done/pass once all 8 combinations have been seen.
- Hardware counterpart to a stimulus driver: the driver applies vectors, this block judges the responses.

Parameters:
- TRUTH_TABLE, 8'hEA: golden Q per input index {A,B,C}; bit i is the expected Q for index i. Default implements (A AND B) OR C.
- CNT_W, 8: width of the sample and error counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  clears all state and arms checking
- in_valid  input  1  sample strobe; A, B, C and Q are sampled when high
- A  input  1  gate input A
- B  input  1  gate input B
- C  input  1  gate input C
- Q  input  1  observed gate output
- busy  output  1  high in CHECK
- done  output  1  high in DONE
- pass  output  1  done AND err_count==0
- fail_pulse  output  1  one-cycle pulse per mismatching sample
- err_count  output  CNT_W  number of mismatches, saturating
- sample_count  output  CNT_W  number of accepted samples, saturating
- coverage  output  8  bit i set once index i has been sampled
- first_fail_idx  output  3  index {A,B,C} of the first mismatch; valid when err_count!=0

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE.
  - All outputs 0: busy, done, pass, fail_pulse, err_count, sample_count, coverage, first_fail_idx.
  - Reset mid-CHECK aborts immediately; no partial results are kept.
- Index: idx = {A,B,C}; expected = TRUTH_TABLE[idx]; mismatch = (Q != expected).
- FSM states: IDLE, CHECK, DONE.
  - IDLE: in_valid is ignored. start -> CHECK.
  - CHECK: on each cycle with in_valid high:
    - sample_count += 1 (saturates at all-ones).
    - coverage[idx] <= 1.
    - If mismatch: err_count += 1 (saturates), fail_pulse=1 next cycle; if err_count was 0, first_fail_idx <= idx.
    - If (coverage | (1<<idx)) == 8'hFF -> DONE in the same edge.
  - DONE: outputs hold. in_valid is ignored. start -> CHECK with a clear.
- start handling:
  - In any state, start at an edge clears counters, coverage, first_fail_idx and fail_pulse, then enters CHECK.
  - start has priority over in_valid in the same cycle; that sample is discarded.
- Latency: all outputs are registered. Effects of a sample appear one cycle after the edge that accepts it; done/pass rise in the same cycle as the final counter update.
- Repeated indices: allowed. They are counted and checked but add no coverage.
- fail_pulse is 0 in every cycle not immediately following an accepted mismatching sample.
- pass is registered and equals (next_state==DONE && next err_count==0).

Optional Feature:
- Macro: CHECKER_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK forces a transition to DONE on that edge, regardless of coverage. pass=0; err_count=1; first_fail_idx and coverage include that sample.
- Undefined: checking continues until coverage is complete, and all mismatches are counted.

Test Plan:
- Reset, then start, then 8 correct samples idx 0..7 (Q=TRUTH_TABLE bits) -> done=1, pass=1, err_count=0, sample_count=8, coverage=8'hFF, fail_pulse never high.
- start, then idx 6 with Q=0 (expected 1), then the remaining 7 indices correct -> fail_pulse once, the cycle after the idx-6 sample; first_fail_idx=6; err_count=1; done=1; pass=0. With CHECKER_STOP_ON_FAIL_EN: done=1 one cycle after the idx-6 sample, sample_count=1, coverage=8'h40.
- start, then idx 0 sent 5 times, then idx 1..7 -> done only after idx 7; sample_count=12, coverage=8'hFF, pass=1.
- Reset asserted mid-CHECK after 4 samples -> all outputs 0 and state IDLE; in_valid samples while in IDLE leave sample_count=0.
- start and in_valid high in the same cycle, both in CHECK and in DONE -> counters cleared, sample discarded, busy=1, sample_count=0.
- CNT_W=2, 5 mismatching samples with TRUTH_TABLE inverted -> err_count saturates at 3, sample_count saturates at 3.
